// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one pipelined 4-bit add-with-carry among NREQ requesters.
// Optional macro ADDER_RR_SCHED_XPORT_DLY_EN adds a #OUT_DLY transport delay on rsp_* (simulation only).
module adder_rr_sched #(
    parameter int NREQ    = 4,
    parameter int LAT     = 3,
    parameter int OUT_DLY = 1,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] a_in,
    input  logic [4*NREQ-1:0] b_in,
    input  logic [NREQ-1:0]   ci_in,
    input  logic              flush,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_vld,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_sum,
    output logic              rsp_co,
    output logic              busy
);

`ifdef ADDER_RR_SCHED_XPORT_DLY_EN
  `define ADDER_RR_SCHED_ODLY #(OUT_DLY)
`else
  `define ADDER_RR_SCHED_ODLY
`endif

    if (NREQ < 2 || NREQ > 8 || LAT < 1 || OUT_DLY < 0) begin : g_bad_param
        $error("adder_rr_sched: parameter out of range");
    end

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic           accept;
    logic [3:0]     a_sel;
    logic [3:0]     b_sel;
    logic           ci_sel;
    logic [4:0]     res;
    int             idx;

    logic [LAT-1:0] p_vld;
    logic [IDW-1:0] p_id  [LAT];
    logic [4:0]     p_res [LAT];

    // Handshake: an operation is accepted at the rising edge where req[i] && gnt[i];
    // the requester keeps req and its operand slice stable until that edge.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        accept  = 1'b0;
        a_sel   = '0;
        b_sel   = '0;
        ci_sel  = 1'b0;
        idx     = 0;
        if (rst_n && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!accept && req[idx]) begin
                    accept   = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = IDW'(idx);
                    a_sel    = a_in[4*idx +: 4];
                    b_sel    = b_in[4*idx +: 4];
                    ci_sel   = ci_in[idx];
                end
            end
        end
    end

    assign res  = {1'b0, a_sel} + {1'b0, b_sel} + {4'b0, ci_sel};
    assign busy = accept | rsp_vld | (|p_vld);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld <= '0;
            for (int j = 0; j < LAT; j++) begin
                p_id[j]  <= '0;
                p_res[j] <= '0;
            end
        end else begin
            p_vld[0] <= accept;
            p_id[0]  <= gnt_idx;
            p_res[0] <= res;
            for (int j = 1; j < LAT; j++) begin
                p_vld[j] <= p_vld[j-1] & ~flush;
                p_id[j]  <= p_id[j-1];
                p_res[j] <= p_res[j-1];
            end
        end
    end

    // Result fields only move on a valid response so they hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld <= 1'b0;
            rsp_id  <= '0;
            rsp_sum <= '0;
            rsp_co  <= 1'b0;
        end else begin
            rsp_vld <= `ADDER_RR_SCHED_ODLY (p_vld[LAT-1] & ~flush);
            if (p_vld[LAT-1] && !flush) begin
                rsp_id            <= `ADDER_RR_SCHED_ODLY p_id[LAT-1];
                {rsp_co, rsp_sum} <= `ADDER_RR_SCHED_ODLY p_res[LAT-1];
            end
        end
    end

`undef ADDER_RR_SCHED_ODLY

endmodule

// File: tb/tb_adder_rr_sched.sv
// Bench for adder_rr_sched: vector table, hand-written corner sequences and random traffic
// checked against a due-time queue model of the scheduler.
module tb_adder_rr_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [4*NREQ-1:0] a_in = '0;
    logic [4*NREQ-1:0] b_in = '0;
    logic [NREQ-1:0]   ci_in = '0;
    logic              flush = 1'b0;
    logic [NREQ-1:0]   gnt;
    logic              rsp_vld;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_sum;
    logic              rsp_co;
    logic              busy;

    always #5 clk = ~clk;

    adder_rr_sched #(.NREQ(NREQ), .LAT(LAT), .OUT_DLY(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .ci_in(ci_in), .flush(flush), .gnt(gnt), .rsp_vld(rsp_vld),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_co(rsp_co), .busy(busy)
    );

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] sum;
        logic       co;
    } vec_t;

    int              n_cmp = 0;
    int              n_err = 0;
    int              edge_n = 0;
    int              mptr = 0;
    int              n_rsp = 0;
    logic [31:0]     exp_q[$];
    logic [IDW-1:0]  h_id = '0;
    logic [4:0]      h_res = '0;
    logic [7:0]      rsp_log[$];
    logic [NREQ-1:0] gnt_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbiter: first asserted request at or after the pointer, modulo NREQ.
    function automatic int model_pick();
        if (!rst_n || flush) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic step();
        int          pick;
        logic        ev;
        logic [31:0] e;
        logic [4:0]  r;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            h_id  = '0;
            h_res = '0;
            mptr  = 0;
        end
        pick = model_pick();
        chk("gnt", 32'(gnt), (pick < 0) ? 32'd0 : (32'd1 << pick));
        ev = 1'b0;
        if (exp_q.size() > 0 && exp_q[0][31:16] == edge_n[15:0]) begin
            e     = exp_q.pop_front();
            ev    = 1'b1;
            h_id  = e[8 +: IDW];
            h_res = e[4:0];
        end
        chk("rsp_vld", 32'(rsp_vld), 32'(ev));
        chk("rsp_id", 32'(rsp_id), 32'(h_id));
        chk("rsp_sum", 32'(rsp_sum), 32'(h_res[3:0]));
        chk("rsp_co", 32'(rsp_co), 32'(h_res[4]));
        chk("busy", 32'(busy), 32'(ev || exp_q.size() > 0 || pick >= 0));
        if (rsp_vld === 1'b1) begin
            n_rsp++;
            rsp_log.push_back({rsp_id, 1'b0, rsp_co, rsp_sum});
        end
        if (gnt != '0) gnt_log.push_back(gnt);
        @(posedge clk);
        edge_n++;
        if (rst_n && flush) begin
            exp_q.delete();
        end else if (pick >= 0) begin
            r = {1'b0, a_in[4*pick +: 4]} + {1'b0, b_in[4*pick +: 4]} + {4'b0, ci_in[pick]};
            exp_q.push_back({16'(edge_n + LAT), 8'(pick), 3'b0, r});
            mptr = (pick + 1) % NREQ;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        flush = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   base;
        tbl[0] = '{0, 4'h7, 4'h9, 1'b1, 4'h1, 1'b1};
        tbl[1] = '{3, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        tbl[2] = '{1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        tbl[3] = '{2, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
        tbl[4] = '{1, 4'h5, 4'h3, 1'b1, 4'h9, 1'b0};
        tbl[5] = '{3, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
        tbl[6] = '{0, 4'h0, 4'hF, 1'b0, 4'hF, 1'b0};

        // Reset held with every request raised
        rst_n = 1'b0;
        req   = 4'hF;
        #1;
        step();
        step();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        req   = '0;

        // Vector table: one operation at a time
        for (int v = 0; v < 7; v++) begin
            a_in  = 16'($urandom);
            b_in  = 16'($urandom);
            ci_in = 4'($urandom);
            a_in[4*tbl[v].id +: 4] = tbl[v].a;
            b_in[4*tbl[v].id +: 4] = tbl[v].b;
            ci_in[tbl[v].id]       = tbl[v].ci;
            req = 4'(1 << tbl[v].id);
            #1;
            chk("tbl_gnt", 32'(gnt), 32'(1 << tbl[v].id));
            step();
            req = '0;
            rsp_log.delete();
            repeat (LAT + 1) step();
            chk("tbl_rsp_cnt", 32'(rsp_log.size()), 32'd1);
            if (rsp_log.size() > 0)
                chk("tbl_rsp", 32'(rsp_log[0]), 32'({2'(tbl[v].id), 1'b0, tbl[v].co, tbl[v].sum}));
            chk("tbl_busy_after", 32'(busy), 32'd0);
        end

        // Full contention: grant order and back-to-back responses
        do_reset();
        gnt_log.delete();
        rsp_log.delete();
        req   = 4'hF;
        a_in  = 16'h3210;
        b_in  = 16'h1111;
        ci_in = '0;
        repeat (8) step();
        req = '0;
        repeat (LAT + 2) step();
        chk("cont_gnt_cnt", 32'(gnt_log.size()), 32'd8);
        chk("cont_rsp_cnt", 32'(rsp_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < gnt_log.size()) chk("cont_gnt_order", 32'(gnt_log[i]), 32'(1 << (i % 4)));
            if (i < rsp_log.size()) chk("cont_sum_seq", 32'(rsp_log[i][4:0]), 32'((i % 4) + 1));
        end

        // Pointer fairness
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b1010;
        #1;
        chk("fair_gnt1", 32'(gnt), 32'b1000);
        step();
        #1;
        chk("fair_gnt2", 32'(gnt), 32'b0010);
        step();
        req = '0;
        repeat (LAT + 2) step();

        // Flush with two operations in flight
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0010;
        step();
        flush = 1'b1;
        #1;
        chk("flush_gnt", 32'(gnt), 32'd0);
        base = n_rsp;
        step();
        flush = 1'b0;
        req   = '0;
        #1;
        chk("flush_busy", 32'(busy), 32'd0);
        repeat (LAT + 2) step();
        chk("flush_no_rsp", 32'(n_rsp - base), 32'd0);

        // Asynchronous reset while a response is showing
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b1000;
        step();
        req = '0;
        step();
        step();
        chk("pre_rst_vld", 32'(rsp_vld), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_now_vld", 32'(rsp_vld), 32'd0);
        chk("rst_now_busy", 32'(busy), 32'd0);
        chk("rst_now_sum", 32'(rsp_sum), 32'd0);
        base = n_rsp;
        step();
        rst_n = 1'b1;
        repeat (LAT + 2) step();
        chk("rst_no_rsp", 32'(n_rsp - base), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req   = 4'($urandom);
            a_in  = 16'($urandom);
            b_in  = 16'($urandom);
            ci_in = 4'($urandom);
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        req   = '0;
        flush = 1'b0;
        repeat (LAT + 2) step();
        chk("rand_drain_busy", 32'(busy), 32'd0);
        chk("rand_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
